rx_uart: RTL and testbench

Asynchronous serial receiver for 8N1 frames, the downstream counterpart of the TX block. It sits on the board-side `uart_rx` pin and synchronises the incoming line. It then locates the start bit, samples each data bit at mid-bit and checks the stop bit. Each received word is delivered to the SoC side as a one-cycle write strobe, with framing errors flagged separately. The default baud timing of 115200 baud from a 100 MHz clock matches the TX block.

---
 rtl/rx_uart.sv | 135 +++++++++++++
 tb/tb_rx_uart.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rx_uart.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | rx_uart : 8N1 serial receiver with mid-bit sampling and framing check     |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module rx_uart #(
   parameter int          BW              = 8,
   parameter logic [23:0] CLOCKS_PER_BAUD = 24'd868
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_uart_rx,
   output logic          o_wr,
   output logic [BW-1:0] o_data,
   output logic          o_frame_err,
   output logic          o_busy
);

   localparam logic [23:0] c_HALF_M1 = (CLOCKS_PER_BAUD >> 1) - 24'd1;
   localparam logic [23:0] c_FULL_M1 = CLOCKS_PER_BAUD - 24'd1;
   localparam int          c_IW      = $clog2(BW + 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_STOP      = 3'd3,
      S_WAIT_HIGH = 3'd4
   } state_t;

   state_t            r_state, w_state_nxt;
   logic              r_sync1, r_rx_s;
   logic [23:0]       r_cnt, w_cnt_nxt;
   logic [BW-1:0]     r_sh, w_sh_nxt;
   logic [c_IW-1:0]   r_idx, w_idx_nxt;
   logic [BW-1:0]     r_data, w_data_nxt;
   logic              r_wr, w_wr_nxt;
   logic              r_ferr, w_ferr_nxt;
   logic              r_busy;
   logic              w_sample;

   assign w_sample = (r_cnt == 24'd0);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1 <= 1'b1;
         r_rx_s  <= 1'b1;
         r_state <= S_IDLE;
         r_cnt   <= 24'd0;
         r_sh    <= '0;
         r_idx   <= '0;
         r_data  <= '0;
         r_wr    <= 1'b0;
         r_ferr  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_sync1 <= i_uart_rx;
         r_rx_s  <= r_sync1;
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_sh    <= w_sh_nxt;
         r_idx   <= w_idx_nxt;
         r_data  <= w_data_nxt;
         r_wr    <= w_wr_nxt;
         r_ferr  <= w_ferr_nxt;
         r_busy  <= (w_state_nxt != S_IDLE);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = (r_cnt != 24'd0) ? r_cnt - 24'd1 : r_cnt;
      w_sh_nxt    = r_sh;
      w_idx_nxt   = r_idx;
      w_data_nxt  = r_data;
      w_wr_nxt    = 1'b0;
      w_ferr_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!r_rx_s) begin
               w_state_nxt = S_START;
               w_cnt_nxt   = c_HALF_M1;
            end
         end
         S_START: begin
            if (w_sample) begin
               if (!r_rx_s) begin
                  w_state_nxt = S_DATA;
                  w_idx_nxt   = '0;
                  w_cnt_nxt   = c_FULL_M1;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (w_sample) begin
               w_sh_nxt  = {r_rx_s, r_sh[BW-1:1]};
               w_cnt_nxt = c_FULL_M1;
               if (r_idx == c_IW'(BW - 1)) begin
                  w_state_nxt = S_STOP;
               end else begin
                  w_idx_nxt = r_idx + c_IW'(1);
               end
            end
         end
         S_STOP: begin
            if (w_sample) begin
               if (r_rx_s) begin
                  w_data_nxt  = r_sh;
                  w_wr_nxt    = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_ferr_nxt  = 1'b1;
                  w_state_nxt = S_WAIT_HIGH;
               end
            end
         end
         S_WAIT_HIGH: begin
            // A held-low line (break) must not be re-read as a stream of zero frames
            if (r_rx_s) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign o_wr        = r_wr;
   assign o_data      = r_data;
   assign o_frame_err = r_ferr;
   assign o_busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_rx_uart.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_rx_uart : scoreboard bench for rx_uart at 16 clocks per bit            |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_rx_uart;

   localparam int CPB = 16;

   typedef struct packed {
      logic       err;
      logic [7:0] data;
   } exp_t;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx    = 1'b1;
   logic       o_wr;
   logic [7:0] o_data;
   logic       o_frame_err;
   logic       o_busy;

   rx_uart #(.BW(8), .CLOCKS_PER_BAUD(24'd16)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_uart_rx   (rx),
      .o_wr        (o_wr),
      .o_data      (o_data),
      .o_frame_err (o_frame_err),
      .o_busy      (o_busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         n_tests = 0;
   int         n_fail  = 0;
   exp_t       sb[$];
   int         strobe_cyc[$];
   logic [7:0] m_last_good = 8'h00;
   logic       prev_busy = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic b);
      rx = b;
      repeat (CPB) step();
   endtask

   // Expected outcome follows directly from the stop bit: good word or framing error
   task automatic send_frame(input logic [7:0] d, input logic stop, output int t0);
      exp_t e;
      t0 = cyc;
      e.err = ~stop;
      if (stop) begin
         e.data      = d;
         m_last_good = d;
      end else begin
         e.data = m_last_good;
      end
      sb.push_back(e);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(stop);
   endtask

   task automatic wait_drain();
      int i;
      i = 0;
      while (sb.size() != 0 && i < 400) begin
         step();
         i++;
      end
      if (sb.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain_timeout: %0d expected strobes outstanding", sb.size());
         sb.delete();
      end
      repeat (20) step();
   endtask

   initial begin
      int   t0, t1, nbusy;
      logic [7:0] d;
      logic st;

      fork
         forever begin
            @(negedge clk);
            if (o_wr || o_frame_err) begin
               strobe_cyc.push_back(cyc);
               chk("strobe_exclusive", 32'(o_wr & o_frame_err), 32'd0);
               if (sb.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_strobe: wr=%0b ferr=%0b data=%0h required none", o_wr, o_frame_err, o_data);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  chk("strobe_kind_ferr", 32'(o_frame_err), 32'(e.err));
                  chk("data", 32'(o_data), 32'(e.data));
                  if (o_wr) chk("busy_fall_with_wr", {30'd0, prev_busy, o_busy}, 32'd2);
               end
            end
            prev_busy = o_busy;
         end
      join_none

      // reset values
      #2;
      chk("rst_wr", 32'(o_wr), 32'd0);
      chk("rst_ferr", 32'(o_frame_err), 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_data", 32'(o_data), 32'd0);
      repeat (3) step();
      rst_n = 1'b1;
      repeat (10) step();

      // single byte with strobe latency
      strobe_cyc.delete();
      send_frame(8'h55, 1'b1, t0);
      wait_drain();
      chk("single_count", strobe_cyc.size(), 32'd1);
      if (strobe_cyc.size() >= 1) chk("single_latency", strobe_cyc[0] - t0, 32'd155);

      // back-to-back
      strobe_cyc.delete();
      send_frame(8'hA5, 1'b1, t0);
      send_frame(8'h3C, 1'b1, t1);
      wait_drain();
      chk("b2b_count", strobe_cyc.size(), 32'd2);
      if (strobe_cyc.size() >= 2) chk("b2b_spacing", strobe_cyc[1] - strobe_cyc[0], 32'd160);

      // start glitch
      nbusy = 0;
      rx = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (o_busy) nbusy++;
         if (i == 4) rx = 1'b1;
      end
      step();
      chk("glitch_busy_cycles", nbusy, 32'd8);
      chk("glitch_data_held", 32'(o_data), 32'(m_last_good));
      repeat (20) step();

      // framing error followed by break
      send_frame(8'hFF, 1'b0, t0);
      repeat (100) step();
      chk("break_busy", 32'(o_busy), 32'd1);
      rx = 1'b1;
      repeat (2) step();
      chk("break_busy_sync", 32'(o_busy), 32'd1);
      step();
      chk("break_release", 32'(o_busy), 32'd0);
      wait_drain();
      send_frame(8'h12, 1'b1, t0);
      wait_drain();

      // asynchronous reset during data bit 3 of 0x81
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      drive_bit(1'b0);
      rx = 1'b0;
      repeat (8) step();
      chk("pre_reset_busy", 32'(o_busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_busy", 32'(o_busy), 32'd0);
      chk("async_rst_data", 32'(o_data), 32'd0);
      chk("async_rst_strobes", {30'd0, o_wr, o_frame_err}, 32'd0);
      m_last_good = 8'h00;
      rx = 1'b1;
      repeat (4) step();
      rst_n = 1'b1;
      repeat (10) step();
      send_frame(8'h7E, 1'b1, t0);
      wait_drain();

      // bit order
      send_frame(8'h01, 1'b1, t0);
      send_frame(8'h80, 1'b1, t0);
      wait_drain();

      // randomized frames with random stop bits and gaps
      for (int k = 0; k < 12; k++) begin
         d  = 8'($urandom_range(0, 255));
         st = ($urandom_range(0, 3) != 0);
         send_frame(d, st, t0);
         rx = 1'b1;
         repeat (st ? $urandom_range(0, 12) : $urandom_range(4, 12)) step();
      end
      wait_drain();
      chk("scoreboard_empty", sb.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
